reg_write_arb: RTL

- Round-robin arbiter that shares the single write port of the processor register file between NUM_REQ write sources, e.g. ALU result, function-processor return and host config.
- Each source uses a valid/ready handshake. The granted write is registered and driven onto the register file write_enable/write_addr/write_data one cycle later.
- Also provides a halt control and a saturating contention counter for debug.

---
 rtl/reg_write_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_write_arb.sv
// reg_write_arb
// Round-robin arbiter that shares the single register-file write port between
// NUM_REQ valid/ready write sources. The winning write is registered and shows
// up on write_* one cycle after its grant. It also has a halt control and a
// saturating contention counter for debug.

module reg_write_arb #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          halt,
   input  logic                          cnt_clear,
   output logic                          write_enable,
   output logic [ADDR_WIDTH-1:0]         write_addr,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic [2:0]                    grant_id,
   output logic [CNT_WIDTH-1:0]          contention_cnt
);

   logic [2:0]            rr_ptr;
   logic [2:0]            gnt_idx;
   logic                  gnt_any;
   logic [NUM_REQ-1:0]    grant;
   logic [3:0]            ptr_sum;
   logic [2:0]            cand;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [3:0]            valid_count;
   logic                  contended;

   // Search for the first valid source starting at rr_ptr, wrapping modulo NUM_REQ.
   // Nothing is granted while in reset or halted.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      ptr_sum = '0;
      cand    = '0;
      if (rst_n && !halt) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            ptr_sum = {1'b0, rr_ptr} + 4'(k);
            if (ptr_sum >= 4'(NUM_REQ)) begin
               ptr_sum = ptr_sum - 4'(NUM_REQ);
            end
            cand = ptr_sum[2:0];
            if (!gnt_any && req_valid[cand]) begin
               gnt_any     = 1'b1;
               gnt_idx     = cand;
               grant[cand] = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;

   // Select the address and data of the granted source for the output register.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Count how many sources are requesting; two or more is contention.
   always_comb begin
      valid_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_count = valid_count + {3'b000, req_valid[i]};
      end
      contended = (valid_count >= 4'd2);
   end

   // Advance the round-robin pointer just past the source that won.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
      end
   end

   // Register the granted write; address, data and id hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         grant_id     <= '0;
      end else begin
         write_enable <= gnt_any;
         if (gnt_any) begin
            write_addr <= sel_addr;
            write_data <= sel_data;
            grant_id   <= gnt_idx;
         end
      end
   end

   // Saturating contention counter; clear wins over increment, halt is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         contention_cnt <= '0;
      end else if (cnt_clear) begin
         contention_cnt <= '0;
      end else if (contended && (contention_cnt != '1)) begin
         contention_cnt <= contention_cnt + 1'b1;
      end
   end

endmodule
